clock_generator: RTL and testbench

CLOCK_GENERATOR -- requirements
Module: clock_generator

---
 rtl/clock_generator_pkg.sv | 23 ++
 rtl/clock_generator_flipflop_112.sv | 61 ++++++
 rtl/clock_generator.sv | 138 +++++++++++++
 tb/tb_clock_generator.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/clock_generator_pkg.sv
// Shared definitions for the four-phase clock generator: phase encodings
// of the Johnson pair and the output values driven while stopped.
package clock_generator_pkg;

  // Johnson pair {q1, q2}; each phase lasts one rawclk period.
  typedef enum logic [1:0] {
    P0 = 2'b10,
    P1 = 2'b11,
    P2 = 2'b01,
    P3 = 2'b00
  } phase_t;

  // Idle (stopped or in reset) output values.
  localparam logic [3:0] IDLE_PHASES = 4'b0000;  // {gc, gc2, gc3, gc4}
  localparam logic       IDLE_GC14   = 1'b1;
  localparam logic       IDLE_GP     = 1'b0;

  // Phase that ends a machine cycle; a stop may only take effect here.
  function automatic logic is_last_phase(input phase_t phase);
    return phase == P3;
  endfunction

endpackage

// File: rtl/clock_generator_flipflop_112.sv
// Dual JK flip-flop with synchronous active-high set and clear per half.
// Clear wins over set; with neither asserted the JK table applies:
// 00 hold, 01 reset, 10 set, 11 toggle.
module flipflop_112 (
  input  logic j_a,
  input  logic k_a,
  input  logic clk_a,
  input  logic set_a,
  input  logic clr_a,
  output logic q_a,
  output logic qn_a,
  input  logic j_b,
  input  logic k_b,
  input  logic clk_b,
  input  logic set_b,
  input  logic clr_b,
  output logic q_b,
  output logic qn_b
);

  logic q_a_reg;
  logic q_b_reg;

  // Half A: clear, then set, then JK behaviour.
  always_ff @(posedge clk_a) begin
    if (clr_a) begin
      q_a_reg <= 1'b0;
    end else if (set_a) begin
      q_a_reg <= 1'b1;
    end else begin
      case ({j_a, k_a})
        2'b01:   q_a_reg <= 1'b0;
        2'b10:   q_a_reg <= 1'b1;
        2'b11:   q_a_reg <= ~q_a_reg;
        default: q_a_reg <= q_a_reg;
      endcase
    end
  end

  // Half B: clear, then set, then JK behaviour.
  always_ff @(posedge clk_b) begin
    if (clr_b) begin
      q_b_reg <= 1'b0;
    end else if (set_b) begin
      q_b_reg <= 1'b1;
    end else begin
      case ({j_b, k_b})
        2'b01:   q_b_reg <= 1'b0;
        2'b10:   q_b_reg <= 1'b1;
        2'b11:   q_b_reg <= ~q_b_reg;
        default: q_b_reg <= q_b_reg;
      endcase
    end
  end

  assign q_a  = q_a_reg;
  assign qn_a = ~q_a_reg;
  assign q_b  = q_b_reg;
  assign qn_b = ~q_b_reg;

endmodule

// File: rtl/clock_generator.sv
// Four-phase machine-cycle clock generator. A Johnson pair (q1, q2) divides
// rawclk by four while the run flag is set; a pending-stop flag lets a halt
// or single step end the clock only after phase P3, so a machine cycle is
// never cut short. All state lives in two dual JK flip-flops.
module clock_generator
  import clock_generator_pkg::*;
(
  input  logic rawclk,
  input  logic reset,
  input  logic halt_n,
  input  logic step,
  input  logic run,
  output logic gc,
  output logic gc2,
  output logic gc3,
  output logic gc4,
  output logic gc14,
  output logic gp
);

  // Registered state from the flip-flops.
  logic q1, q1_n;
  logic q2, q2_n;
  logic running, running_n;
  logic stop_pending, stop_pending_n;

  // Decoded control.
  phase_t phase;
  logic   start;
  logic   start_step;
  logic   stop_now;

  // JK / set / clear controls for each flip-flop.
  logic q1_j, q1_k, q1_set, q1_clr;
  logic q2_j, q2_k, q2_set, q2_clr;
  logic run_j, run_k, run_set, run_clr;
  logic sp_j, sp_k, sp_set, sp_clr;

  assign phase = phase_t'({q1, q2});

  // Start and stop decisions, ordered reset > halt > step > run.
  always_comb begin
    start      = 1'b0;
    start_step = 1'b0;
    stop_now   = 1'b0;
    if (!running) begin
      // A low halt_n blocks any start while stopped.
      if (halt_n && (step || run)) begin
        start      = 1'b1;
        start_step = step;
      end
    end else begin
      stop_now = stop_pending && is_last_phase(phase);
    end
  end

  // Flip-flop drive: the Johnson pair advances only while running,
  // start loads P0 and a stop or reset returns everything to zero.
  always_comb begin
    // Phase bit q1 follows ~q2 while running, otherwise holds.
    q1_j    = running & q2_n;
    q1_k    = running & q2;
    q1_set  = start;
    q1_clr  = reset | stop_now;
    // Phase bit q2 follows q1 while running; start forces it low for P0.
    q2_j    = running & q1;
    q2_k    = running & q1_n;
    q2_set  = 1'b0;
    q2_clr  = reset | stop_now | start;
    // Run flag: set on start, cleared on stop; never toggled.
    run_j   = 1'b0;
    run_k   = 1'b0;
    run_set = start;
    run_clr = reset | stop_now;
    // Stop request: raised by a step or by a halt seen while running.
    // Clearing at the end of the cycle wins over a fresh halt.
    sp_j    = 1'b0;
    sp_k    = 1'b0;
    sp_set  = start_step | (running & stop_pending_n & ~halt_n);
    sp_clr  = reset | stop_now;
  end

  // Phase divider: half A is q1, half B is q2.
  flipflop_112 u_phase_ff (
    .j_a   (q1_j),
    .k_a   (q1_k),
    .clk_a (rawclk),
    .set_a (q1_set),
    .clr_a (q1_clr),
    .q_a   (q1),
    .qn_a  (q1_n),
    .j_b   (q2_j),
    .k_b   (q2_k),
    .clk_b (rawclk),
    .set_b (q2_set),
    .clr_b (q2_clr),
    .q_b   (q2),
    .qn_b  (q2_n)
  );

  // Control flags: half A is the run flag, half B the pending stop.
  flipflop_112 u_ctrl_ff (
    .j_a   (run_j),
    .k_a   (run_k),
    .clk_a (rawclk),
    .set_a (run_set),
    .clr_a (run_clr),
    .q_a   (running),
    .qn_a  (running_n),
    .j_b   (sp_j),
    .k_b   (sp_k),
    .clk_b (rawclk),
    .set_b (sp_set),
    .clr_b (sp_clr),
    .q_b   (stop_pending),
    .qn_b  (stop_pending_n)
  );

  // Output decode from registered state only; idle values while stopped.
  always_comb begin
    gc   = IDLE_PHASES[3];
    gc2  = IDLE_PHASES[2];
    gc3  = IDLE_PHASES[1];
    gc4  = IDLE_PHASES[0];
    gc14 = IDLE_GC14;
    gp   = IDLE_GP;
    if (!running_n) begin
      gc   = q1;
      gc2  = q2;
      gc3  = q1_n;
      gc4  = q2_n;
      // Low only in P2, where gc2 and gc3 are both high.
      gc14 = ~(q2 & q1_n);
      gp   = 1'b1;
    end
  end

endmodule

// File: tb/tb_clock_generator.sv
// Directed bench for clock_generator. Outputs are packed as
// {gc, gc2, gc3, gc4, gc14, gp} and checked 1 ns after each rising edge.
module tb_clock_generator;

  logic rawclk = 1'b0;
  logic reset;
  logic halt_n;
  logic step;
  logic run;
  logic gc, gc2, gc3, gc4, gc14, gp;
  logic [5:0] outs;

  int assert_cnt = 0;
  int fail_cnt   = 0;

  // Hand-computed output vectors.
  localparam logic [5:0] IDLE   = 6'b0000_1_0;
  localparam logic [5:0] EXP_P0 = 6'b1001_1_1;
  localparam logic [5:0] EXP_P1 = 6'b1100_1_1;
  localparam logic [5:0] EXP_P2 = 6'b0110_0_1;
  localparam logic [5:0] EXP_P3 = 6'b0011_1_1;

  logic [5:0] cycle_exp [4];

  clock_generator dut (
    .rawclk (rawclk),
    .reset  (reset),
    .halt_n (halt_n),
    .step   (step),
    .run    (run),
    .gc     (gc),
    .gc2    (gc2),
    .gc3    (gc3),
    .gc4    (gc4),
    .gc14   (gc14),
    .gp     (gp)
  );

  assign outs = {gc, gc2, gc3, gc4, gc14, gp};

  always #5 rawclk = ~rawclk;

  // Advance one rawclk edge and settle past it.
  task automatic tick();
    @(posedge rawclk);
    #1;
  endtask

  // Single comparison point: counts, logs and reports mismatches.
  task automatic check_eq(input string tag, input logic [5:0] got, input logic [5:0] exp);
    assert_cnt++;
    if (got !== exp) begin
      fail_cnt++;
      $display("[%0t] FAIL %s got=%b expected=%b", $time, tag, got, exp);
    end else begin
      $display("[%0t] ok   %s got=%b", $time, tag, got);
    end
  endtask

  // Check one full machine cycle starting at P0, advancing after each phase.
  task automatic check_cycle(input string tag);
    for (int i = 0; i < 4; i++) begin
      check_eq($sformatf("%s_p%0d", tag, i), outs, cycle_exp[i]);
      tick();
    end
  endtask

  initial begin
    cycle_exp[0] = EXP_P0;
    cycle_exp[1] = EXP_P1;
    cycle_exp[2] = EXP_P2;
    cycle_exp[3] = EXP_P3;

    // Reset held for two cycles.
    reset = 1'b1; halt_n = 1'b1; step = 1'b0; run = 1'b0;
    tick(); tick();
    check_eq("reset_held", outs, IDLE);
    reset = 1'b0;
    tick();
    check_eq("after_reset", outs, IDLE);

    // Free run: one-cycle run pulse, then two full machine cycles.
    run = 1'b1;
    tick();
    run = 1'b0;
    check_cycle("run_c0");
    check_cycle("run_c1");

    // Halt sampled at the end of P1: P2 and P3 still complete.
    tick();                           // now in P1
    halt_n = 1'b0;
    check_eq("halt_p1", outs, EXP_P1);
    tick();
    halt_n = 1'b1;
    check_eq("halt_p2", outs, EXP_P2);
    tick();
    check_eq("halt_p3", outs, EXP_P3);
    tick();
    check_eq("halt_stopped", outs, IDLE);

    // run with halt_n low while stopped is blocked.
    halt_n = 1'b0; run = 1'b1;
    tick();
    check_eq("run_blocked_0", outs, IDLE);
    tick();
    check_eq("run_blocked_1", outs, IDLE);
    halt_n = 1'b1; run = 1'b0;
    tick();
    check_eq("run_blocked_2", outs, IDLE);

    // Single step: exactly one machine cycle, then stopped.
    step = 1'b1;
    tick();
    step = 1'b0;
    check_cycle("step");
    check_eq("step_end_0", outs, IDLE);
    tick();
    check_eq("step_end_1", outs, IDLE);

    // run and step together behave as a step.
    run = 1'b1; step = 1'b1;
    tick();
    run = 1'b0; step = 1'b0;
    check_cycle("runstep");
    check_eq("runstep_end_0", outs, IDLE);
    tick();
    check_eq("runstep_end_1", outs, IDLE);

    // Reset during P2 aborts the cycle immediately.
    run = 1'b1;
    tick();
    run = 1'b0;
    check_eq("rst_mid_p0", outs, EXP_P0);
    tick();
    tick();
    check_eq("rst_mid_p2", outs, EXP_P2);
    reset = 1'b1;
    tick();
    check_eq("rst_mid_abort", outs, IDLE);
    reset = 1'b0;
    tick();
    check_eq("rst_mid_idle", outs, IDLE);
    run = 1'b1;
    tick();
    run = 1'b0;
    check_eq("rst_restart_p0", outs, EXP_P0);
    tick();
    check_eq("rst_restart_p1", outs, EXP_P1);

    // Stop from free run via halt, then a held step restarts once per stop.
    halt_n = 1'b0;
    tick();                           // P2
    halt_n = 1'b1;
    tick();                           // P3
    tick();
    check_eq("pre_hold_idle", outs, IDLE);
    step = 1'b1; run = 1'b1;
    tick();
    check_cycle("hold_c0");
    check_eq("hold_gap", outs, IDLE);
    tick();
    step = 1'b0; run = 1'b0;
    check_cycle("hold_c1");
    check_eq("hold_end", outs, IDLE);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
